aes_dec_sched: RTL and testbench

Iterative AES-128 decryption scheduler. It drives one shared inverse-round datapath through all ten rounds, replacing ten unrolled round instances with a single time-multiplexed one. It accepts a ciphertext/key pair over a valid/ready handshake and first runs forward key expansion into an 11-entry round-key buffer. It then applies the round keys in reverse order and returns the plaintext over a second valid/ready handshake. It sits between the host-side block buffer and the output FIFO of the decrypt path.

---
 rtl/aes_dec_sched_pkg.sv | 74 +++++++
 rtl/aes_dec_sched_prims.sv | 53 +++++
 rtl/aes_inv_round_core.sv | 16 +
 rtl/aes_dec_sched.sv | 119 +++++++++++
 tb/tb_aes_dec_sched.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_dec_sched_pkg.sv
// aes_pkg: shared block type, scheduler FSM states, round constants and
// GF(2^8) helpers used by the iterative AES-128 decrypt path.
package aes_pkg;
  localparam int unsigned NR = 10;

  typedef logic [15:0][7:0] block_t;
  typedef enum logic [1:0] {ST_IDLE, ST_EXPAND, ST_DECRYPT, ST_DONE} state_t;

  localparam logic [7:0] RCON [NR] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                       8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  function automatic logic [7:0] rcon_at(input logic [3:0] i);
    return (i < 4'(NR)) ? RCON[i] : 8'h00;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse computed as a^254 (0 maps to 0) instead of a table.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] sq, r;
    sq = a;
    r  = 8'h01;
    for (int unsigned i = 0; i < 7; i++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int unsigned n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] g;
    g = ginv(a);
    return g ^ rotl8(g, 1) ^ rotl8(g, 2) ^ rotl8(g, 3) ^ rotl8(g, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return ginv(rotl8(b, 1) ^ rotl8(b, 3) ^ rotl8(b, 6) ^ 8'h05);
  endfunction

  function automatic block_t inv_mix_columns(input block_t s);
    block_t     o;
    logic [7:0] cf [4];
    logic [7:0] a  [4];
    logic [7:0] acc;
    cf = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    o  = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned k = 0; k < 4; k++) a[k] = s[4'(15 - 4 * c - k)];
      for (int unsigned r = 0; r < 4; r++) begin
        acc = '0;
        for (int unsigned k = 0; k < 4; k++) acc ^= gmul(cf[2'((k + 4 - r) % 4)], a[k]);
        o[4'(15 - 4 * c - r)] = acc;
      end
    end
    return o;
  endfunction
endpackage

// File: rtl/aes_dec_sched_prims.sv
// AES byte/word primitives: inverse S-box layer, InvShiftRows, AddRoundKey
// and one step of forward AES-128 key expansion.
module inv_substitute import aes_pkg::*; (
  input  logic [15:0][7:0] i_state,
  output logic [15:0][7:0] o_state
);
  always_comb begin
    o_state = '0;
    for (int unsigned i = 0; i < 16; i++) o_state[4'(i)] = inv_sbox(i_state[4'(i)]);
  end
endmodule

module invshiftrows (
  input  logic [15:0][7:0] i_state,
  output logic [15:0][7:0] o_state
);
  // Byte 4c+r (FIPS order) sits at packed index 15-(4c+r).
  always_comb begin
    o_state = '0;
    for (int unsigned c = 0; c < 4; c++)
      for (int unsigned r = 0; r < 4; r++)
        o_state[4'(15 - 4 * c - r)] = i_state[4'(15 - 4 * ((c + 4 - r) % 4) - r)];
  end
endmodule

module invkeyadd (
  input  logic [15:0][7:0] i_state,
  input  logic [15:0][7:0] i_key,
  output logic [15:0][7:0] o_state
);
  assign o_state = i_state ^ i_key;
endmodule

module keyexpand import aes_pkg::*; (
  input  logic [15:0][7:0] i_key,
  input  logic [7:0]       i_rcon,
  output logic [15:0][7:0] o_key
);
  logic [3:0][31:0] w_w, w_n;
  logic [31:0]      w_t;

  // w_w[3] is the first key word (FIPS bytes 0..3).
  always_comb begin
    w_w    = i_key;
    w_t    = {sbox(w_w[0][23:16]), sbox(w_w[0][15:8]), sbox(w_w[0][7:0]),
              sbox(w_w[0][31:24])} ^ {i_rcon, 24'h0};
    w_n[3] = w_w[3] ^ w_t;
    w_n[2] = w_w[2] ^ w_n[3];
    w_n[1] = w_w[1] ^ w_n[2];
    w_n[0] = w_w[0] ^ w_n[1];
    o_key  = w_n;
  end
endmodule

// File: rtl/aes_inv_round_core.sv
// Combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless i_last is set.
module aes_inv_round_core import aes_pkg::*; (
  input  logic [15:0][7:0] i_state,
  input  logic [15:0][7:0] i_rkey,
  input  logic             i_last,
  output logic [15:0][7:0] o_state
);
  logic [15:0][7:0] w_shift, w_sub, w_add;

  invshiftrows   u_isr (.i_state(i_state), .o_state(w_shift));
  inv_substitute u_isb (.i_state(w_shift), .o_state(w_sub));
  invkeyadd      u_iak (.i_state(w_sub),   .i_key(i_rkey), .o_state(w_add));

  assign o_state = i_last ? w_add : inv_mix_columns(w_add);
endmodule

// File: rtl/aes_dec_sched.sv
// Iterative AES-128 decrypt scheduler: expands the key into an 11-entry
// buffer, then runs one shared inverse round ten times. AES_KEY_CACHE_EN skips expansion on key reuse.
module aes_dec_sched import aes_pkg::*; (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0][7:0] in_data,
  input  logic [15:0][7:0] in_key,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0][7:0] out_data,
  output logic             busy
);
  localparam logic [3:0] LAST = 4'(NR);

  state_t     r_st;
  block_t     r_state;
  block_t     r_rk [NR + 1];
  logic [3:0] r_kcnt, r_rnd;
  logic       r_in_ready, r_out_valid, r_busy;
  block_t     w_rk, w_kprev, w_knext, w_round;
  logic [7:0] w_rcon;
  logic       w_accept, w_hit;

  assign w_accept = (r_st == ST_IDLE) && in_valid && r_in_ready;
  assign w_rk     = r_rk[r_rnd];
  assign w_kprev  = r_rk[(r_kcnt == 4'd0) ? 4'd0 : r_kcnt - 4'd1];
  assign w_rcon   = rcon_at(r_kcnt - 4'd1);

`ifdef AES_KEY_CACHE_EN
  block_t r_ckey;
  logic   r_cvalid;
  assign w_hit = r_cvalid && (in_key == r_ckey);
`else
  assign w_hit = 1'b0;
`endif

  keyexpand u_ke (.i_key(w_kprev), .i_rcon(w_rcon), .o_key(w_knext));

  aes_inv_round_core u_core (
    .i_state(r_state), .i_rkey(w_rk), .i_last(r_rnd == 4'd0), .o_state(w_round)
  );

  // Buffer contents need no reset; only the FSM decides which entries are live.
  always_ff @(posedge clk) begin
    if (w_accept)               r_rk[0]      <= in_key;
    else if (r_st == ST_EXPAND) r_rk[r_kcnt] <= w_knext;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st        <= ST_IDLE;
      r_state     <= '0;
      r_kcnt      <= '0;
      r_rnd       <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
`ifdef AES_KEY_CACHE_EN
      r_ckey      <= '0;
      r_cvalid    <= 1'b0;
`endif
    end else begin
      case (r_st)
        ST_IDLE: begin
          r_in_ready <= !w_accept;
          if (w_accept) begin
            r_state <= in_data;
            r_busy  <= 1'b1;
            if (w_hit) begin
              r_st  <= ST_DECRYPT;
              r_rnd <= LAST;
            end else begin
              r_st   <= ST_EXPAND;
              r_kcnt <= 4'd1;
            end
          end
        end
        ST_EXPAND: begin
          if (r_kcnt == LAST) begin
            r_st   <= ST_DECRYPT;
            r_rnd  <= LAST;
            r_kcnt <= '0;
`ifdef AES_KEY_CACHE_EN
            r_ckey   <= r_rk[0];
            r_cvalid <= 1'b1;
`endif
          end else begin
            r_kcnt <= r_kcnt + 4'd1;
          end
        end
        ST_DECRYPT: begin
          r_state <= (r_rnd == LAST) ? (r_state ^ w_rk) : w_round;
          if (r_rnd == 4'd0) begin
            r_st        <= ST_DONE;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b1;
          end else begin
            r_rnd <= r_rnd - 4'd1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_st        <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: r_st <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_state;
  assign busy      = r_busy;
endmodule

// File: tb/tb_aes_dec_sched.sv
// Bench for aes_dec_sched: random plaintexts are encrypted by a forward AES
// model, the ciphertext is fed in, and a monitor scores plaintext and latency.
module tb_aes_dec_sched;
  logic             clk = 1'b0;
  logic             rst, in_valid, in_ready, out_valid, out_ready, busy;
  logic [15:0][7:0] in_data, in_key, out_data;

  aes_dec_sched dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_key(in_key), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- forward AES-128 reference model ----------------
  logic [7:0] sb [256];

  function automatic logic [7:0] rl(input logic [7:0] x, input int n);
    return 8'((x << n) | (x >> (8 - n)));
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] a);
    return 8'(a << 1) ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // S-box generated by walking the multiplicative group with generator 3.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ 8'(p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ 8'(q << 1);
      q = q ^ 8'(q << 2);
      q = q ^ 8'(q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rl(q, 1) ^ rl(q, 2) ^ rl(q, 3) ^ rl(q, 4);
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
  endtask

  function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [127:0] key);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] ks [176];
    logic [7:0] w [4];
    logic [7:0] a [4];
    logic [7:0] rc;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) begin
      s[i]  = pt[127 - 8 * i -: 8];
      ks[i] = key[127 - 8 * i -: 8];
    end
    rc = 8'h01;
    for (int i = 16; i < 176; i += 4) begin
      for (int j = 0; j < 4; j++) w[j] = ks[i - 4 + j];
      if (i % 16 == 0) begin
        a[0] = sb[w[1]] ^ rc;
        a[1] = sb[w[2]];
        a[2] = sb[w[3]];
        a[3] = sb[w[0]];
        w    = a;
        rc   = xt(rc);
      end
      for (int j = 0; j < 4; j++) ks[i + j] = ks[i - 16 + j] ^ w[j];
    end
    for (int i = 0; i < 16; i++) s[i] ^= ks[i];
    for (int rd = 1; rd <= 10; rd++) begin
      for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[4 * c + r] = s[4 * ((c + r) % 4) + r];
      if (rd < 10) begin
        for (int c = 0; c < 4; c++) begin
          for (int r = 0; r < 4; r++) a[r] = t[4 * c + r];
          for (int r = 0; r < 4; r++)
            s[4 * c + r] = xt(a[r]) ^ xt(a[(r + 1) % 4]) ^ a[(r + 1) % 4]
                         ^ a[(r + 2) % 4] ^ a[(r + 3) % 4];
        end
      end else begin
        s = t;
      end
      for (int i = 0; i < 16; i++) s[i] ^= ks[16 * rd + i];
    end
    for (int i = 0; i < 16; i++) res[127 - 8 * i -: 8] = s[i];
    return res;
  endfunction

`ifdef AES_KEY_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif
  bit           m_cv = 1'b0;
  logic [127:0] m_ck = '0;

  function automatic int exp_lat(input logic [127:0] key);
    return (CACHE && m_cv && key == m_ck) ? 11 : 21;
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [127:0] pt;
    int           lat;
  } exp_t;
  exp_t         exp_q [$];
  int           acc_q [$];
  bit           armed = 1'b0;
  bit           prev_v = 1'b0;
  bit           chk_next = 1'b0;
  logic [127:0] held = '0;

  always @(negedge clk) begin
    exp_t e;
    int   t;
    if (rst) begin
      prev_v   = 1'b0;
      chk_next = 1'b0;
    end else begin
      if (chk_next) begin
        check("in_ready_after_out", in_ready, 1'b1);
        check("out_valid_dropped", out_valid, 1'b0);
        chk_next = 1'b0;
      end
      if (in_valid && in_ready) begin
        if (!armed) check("extra_accept", in_ready, 1'b0);
        acc_q.push_back(cyc + 1);
      end
      if (out_valid) begin
        if (!prev_v) begin
          if (exp_q.size() == 0 || acc_q.size() == 0) begin
            check("unexpected_out", out_valid, 1'b0);
          end else begin
            e = exp_q.pop_front();
            t = acc_q.pop_front();
            check("plaintext", out_data, e.pt);
            check("latency", 128'(cyc - t), 128'(e.lat));
            held = e.pt;
          end
        end else begin
          check("out_data_stable", out_data, held);
        end
        check("in_ready_in_done", in_ready, 1'b0);
        if (out_ready) chk_next = 1'b1;
      end
      prev_v = out_valid;
    end
  end

  // ---------------- driver ----------------
  task automatic run_block(input logic [127:0] ct, input logic [127:0] key,
                           input logic [127:0] pt, input int hold,
                           input bit garbage, input bit abort);
    int   n;
    exp_t e;
    e.pt  = pt;
    e.lat = exp_lat(key);
    @(posedge clk); #2;
    in_data   = ct;
    in_key    = key;
    in_valid  = 1'b1;
    armed     = 1'b1;
    out_ready = (hold == 0);
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #2;
      n++;
    end
    check("in_ready_seen", in_ready, 1'b1);
    if (!in_ready) begin
      in_valid = 1'b0;
      armed    = 1'b0;
      return;
    end
    exp_q.push_back(e);
    @(posedge clk); #2;
    armed    = 1'b0;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin
      if (abort && n == 15) begin
        rst = 1'b1;
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_in_ready", in_ready, 1'b0);
        @(posedge clk); #2;
        rst = 1'b0;
        exp_q.delete();
        acc_q.delete();
        m_cv     = 1'b0;
        in_valid = 1'b0;
        return;
      end
      check("busy_while_running", busy, 1'b1);
      if (garbage) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = {$urandom, $urandom, $urandom, $urandom};
        in_key   = {$urandom, $urandom, $urandom, $urandom};
      end
      @(posedge clk); #2;
      n++;
    end
    in_valid = 1'b0;
    check("out_valid_seen", out_valid, 1'b1);
    check("busy_done", busy, 1'b0);
    if (hold > 0) begin
      repeat (hold) begin
        @(posedge clk); #2;
      end
      out_ready = 1'b1;
    end
    @(posedge clk); #2;
    out_ready = 1'b0;
    m_cv = 1'b1;
    m_ck = key;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, tests=%0d", tests);
    $fatal(1, "timeout");
  end

  initial begin
    logic [127:0] k, p;
    build_sbox();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_key = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", in_ready, 1'b0);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_out_data", out_data, '0);
    check("reset_busy", busy, 1'b0);
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #2;
    check("in_ready_after_reset", in_ready, 1'b1);

    run_block(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h000102030405060708090a0b0c0d0e0f,
              128'h00112233445566778899aabbccddeeff, 0, 1'b0, 1'b0);
    run_block(128'h3925841d02dc09fbdc118597196a0b32, 128'h2b7e151628aed2a6abf7158809cf4f3c,
              128'h3243f6a8885a308d313198a2e0370734, 0, 1'b1, 1'b0);

    k = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    p = {$urandom, $urandom, $urandom, $urandom};
    run_block(encrypt(p, k), k, p, 50, 1'b1, 1'b0);

    for (int i = 0; i < 8; i++) begin
      if (i % 3 == 0) k = {$urandom, $urandom, $urandom, $urandom};
      p = {$urandom, $urandom, $urandom, $urandom};
      run_block(encrypt(p, k), k, p, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0);
    end

    k = 128'h000102030405060708090a0b0c0d0e0f;
    run_block(128'h69c4e0d86a7b0430d8cdb78070b4c55a, k,
              128'h00112233445566778899aabbccddeeff, 0, 1'b0, 1'b0);
    p = {$urandom, $urandom, $urandom, $urandom};
    run_block(encrypt(p, k), k, p, 0, 1'b0, 1'b1);
    run_block(128'h69c4e0d86a7b0430d8cdb78070b4c55a, k,
              128'h00112233445566778899aabbccddeeff, 0, 1'b0, 1'b0);
    p = {$urandom, $urandom, $urandom, $urandom};
    run_block(encrypt(p, k), k, p, 0, 1'b1, 1'b0);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 128'(exp_q.size()), '0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
